mbinit_sb_arbiter: RTL

- Sequential arbiter that shares the single sideband message encoder between up to four MBINIT sub-state requesters, for example the PARAM uplink and downlink FSMs.
- Replaces the combinational priority mux with round-robin grant and a latched message.
- Runs a one-message-in-flight handshake against `i_sb_busy`, plus a busy watchdog.
- Sits between the MBINIT sub-state FSMs and the sideband encoder.

---
 rtl/mbinit_pkg.sv | 32 +++
 rtl/mbinit_sb_arbiter_rr_pick.sv | 26 ++
 rtl/mbinit_sb_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband arbiter states, message width default and
// the sideband message codes issued by the MBINIT sub-state requesters.
package mbinit_pkg;

    localparam int SB_MSG_WIDTH_DEF = 4;
    localparam int N_REQ_MAX        = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ERR
    } sb_arb_state_e;

    localparam logic [3:0] MSG_NOP          = 4'h0;
    localparam logic [3:0] MSG_PARAM_REQ    = 4'h1;
    localparam logic [3:0] MSG_PARAM_RSP    = 4'h2;
    localparam logic [3:0] MSG_CAL_DONE_REQ = 4'h3;
    localparam logic [3:0] MSG_CAL_DONE_RSP = 4'h4;
    localparam logic [3:0] MSG_REPCLK_REQ   = 4'h5;
    localparam logic [3:0] MSG_REPCLK_RSP   = 4'h6;
    localparam logic [3:0] MSG_REPVAL_REQ   = 4'h7;
    localparam logic [3:0] MSG_REPVAL_RSP   = 4'h8;
    localparam logic [3:0] MSG_REVERSAL_REQ = 4'h9;
    localparam logic [3:0] MSG_REVERSAL_RSP = 4'hA;

    // Round-robin successor of a grant index over n requesters.
    function automatic logic [1:0] rr_next(input logic [1:0] id, input int n);
        return (int'(id) == n - 1) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/mbinit_sb_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: lowest-offset valid request
// at or after the start pointer, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    always_comb begin
        any = 1'b0;
        idx = 2'd0;
        // Walk offsets from farthest to nearest so the nearest hit is kept.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (k == (int'(ptr) + i) % N_REQ && req[k]) begin
                    any = 1'b1;
                    idx = 2'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mbinit_sb_arbiter.sv
// Round-robin arbiter sharing the sideband encoder between MBINIT sub-state FSMs:
// latches one message, handshakes it against i_sb_busy and guards it with a watchdog.
module mbinit_sb_arbiter
    import mbinit_pkg::*;
#(
    parameter int SB_MSG_Width = SB_MSG_WIDTH_DEF,
    parameter int N_REQ        = 2,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_MBINIT_en,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*SB_MSG_Width-1:0] i_req_msg,
    input  logic                          i_sb_busy,
    input  logic                          i_err_clear,
    output logic [SB_MSG_Width-1:0]       o_encoded_SB_msg,
    output logic                          o_msg_valid,
    output logic [N_REQ-1:0]              o_req_ack,
    output logic [1:0]                    o_grant_id,
    output logic                          o_busy,
    output logic                          o_timeout_err
);

    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    sb_arb_state_e           state, state_nx;
    logic [WDW-1:0]          wd_cnt, wd_inc;
    logic                    wd_expire;
    logic [1:0]              rr_ptr;
    logic                    busy_q, busy_fall;
    logic [N_REQ-1:0]        req_eff, ack_vec;
    logic                    pick_any;
    logic [1:0]              pick_idx;
    logic [SB_MSG_Width-1:0] pick_msg;
    logic                    grant_fire, ack_fire;

    // The requester being acked still shows its old valid this cycle; mask it
    // so a stale level is not granted a second time.
    assign req_eff = i_req_valid & ~o_req_ack;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (req_eff),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        pick_msg = '0;
        ack_vec  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx == 2'(k))
                pick_msg = i_req_msg[k*SB_MSG_Width +: SB_MSG_Width];
            ack_vec[k] = (o_grant_id == 2'(k));
        end
    end

    assign wd_inc    = (wd_cnt == WDW'(TIMEOUT_CYC)) ? wd_cnt : wd_cnt + 1'b1;
    assign wd_expire = (wd_inc == WDW'(TIMEOUT_CYC));
    assign busy_fall = busy_q & ~i_sb_busy;

    always_comb begin
        state_nx   = state;
        grant_fire = 1'b0;
        ack_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_MBINIT_en && pick_any) begin
                    grant_fire = 1'b1;
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_MBINIT_en)    state_nx = S_IDLE;
                else if (wd_expire)  state_nx = S_ERR;
                else if (i_sb_busy)  state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!i_MBINIT_en)    state_nx = S_IDLE;
                else if (wd_expire)  state_nx = S_ERR;
                else if (busy_fall) begin
                    ack_fire = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_ERR: begin
                if (i_err_clear)     state_nx = S_IDLE;
            end
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= S_IDLE;
            wd_cnt           <= '0;
            rr_ptr           <= 2'd0;
            busy_q           <= 1'b0;
            o_encoded_SB_msg <= '0;
            o_msg_valid      <= 1'b0;
            o_req_ack        <= '0;
            o_grant_id       <= 2'd0;
            o_busy           <= 1'b0;
            o_timeout_err    <= 1'b0;
        end else begin
            state         <= state_nx;
            busy_q        <= i_sb_busy;
            o_msg_valid   <= (state_nx == S_ISSUE);
            o_busy        <= (state_nx == S_ISSUE) || (state_nx == S_WAIT_DONE);
            o_timeout_err <= (state_nx == S_ERR);
            o_req_ack     <= ack_fire ? ack_vec : '0;

            if (grant_fire) begin
                o_encoded_SB_msg <= pick_msg;
                o_grant_id       <= pick_idx;
                wd_cnt           <= '0;
            end else if (state == S_ISSUE || state == S_WAIT_DONE) begin
                wd_cnt <= wd_inc;
            end

            if (ack_fire)
                rr_ptr <= rr_next(o_grant_id, N_REQ);
        end
    end

endmodule
